laser_uart_frame_ctrl: RTL and testbench

LASER_UART_FRAME_CTRL -- requirements
Module: laser_uart_frame_ctrl

---
 rtl/laser_uart_frame_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_laser_uart_frame_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_uart_frame_ctrl.sv
// laser_uart_frame_ctrl: word-FIFO UART transmitter with EOF truncation and framed byte receiver.
// Define LASER_UART_RX_TIMEOUT_EN to add the RX partial-frame idle timeout.
module laser_uart_frame_ctrl #(
   parameter real         TCQ            = 0.1,
   parameter logic [15:0] PRESCALE       = 16'd108,
   parameter int          TX_WORD_BYTES  = 4,
   parameter int          FIFO_DEPTH     = 16,
   parameter logic [7:0]  EOF_BYTE       = 8'hFF,
   parameter logic [31:0] RX_TIMEOUT_CYC = 32'd100000
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [8*TX_WORD_BYTES-1:0] laser_tx_data_i,
   input  logic                       laser_tx_vld_i,
   output logic                       laser_tx_full_o,
   output logic                       laser_tx_busy_o,
   output logic [7:0]                 laser_rx_data_o,
   output logic                       laser_rx_vld_o,
   output logic                       laser_rx_last_o,
   output logic                       laser_rx_err_o,
   output logic                       laser_rx_timeout_o,
   input  logic                       LASER_UART_RXD,
   output logic                       LASER_UART_TXD
);
   localparam int BIT  = 8 * int'(PRESCALE);
   localparam int HALF = 4 * int'(PRESCALE);
   localparam int CW   = $clog2(BIT + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int WW   = 8 * TX_WORD_BYTES;
   if (TCQ < 0.0 || TX_WORD_BYTES < 1 || TX_WORD_BYTES > 8 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PRESCALE == 16'd0 || RX_TIMEOUT_CYC == 32'd0) begin : g_bad_cfg
      $error("laser_uart_frame_ctrl: invalid parameter set");
   end
   logic [WW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wp, rp;
   logic          empty, wr, pop;
   logic [WW-1:0] rd_word;
   assign empty           = wp == rp;
   assign laser_tx_full_o = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign wr              = laser_tx_vld_i && !laser_tx_full_o;
   assign rd_word         = mem[rp[AW-1:0]];
   always_ff @(posedge clk_i) if (wr) mem[wp[AW-1:0]] <= laser_tx_data_i;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wp <= '0;
         rp <= '0;
      end else begin
         wp <= wp + {{AW{1'b0}}, wr};
         rp <= rp + {{AW{1'b0}}, pop};
      end
   end
   typedef enum logic [2:0] {T_IDLE, T_LOAD, T_START, T_DATA, T_STOP, T_NEXT} tx_st_t;
   tx_st_t        ts, ts_n;
   logic [CW-1:0] tcnt, tcnt_n;
   logic [2:0]    tbit, tbit_n, tidx, tidx_n;
   logic [7:0]    tsh, tsh_n;
   logic [WW-1:0] tw, tw_n, tw_shl;
   logic          more, tbit_end;
   assign tw_shl          = tw << 8;
   assign more            = (tidx != 3'(TX_WORD_BYTES - 1)) && (tw[WW-1 -: 8] != EOF_BYTE);
   assign tbit_end        = tcnt == CW'(BIT - 1);
   assign laser_tx_busy_o = !empty || ts != T_IDLE;
   // Stop bit is trimmed by the NEXT (and LOAD) cycles so consecutive frames abut exactly.
   always_comb begin
      ts_n   = ts;
      tcnt_n = tcnt + 1'b1;
      tbit_n = tbit;
      tsh_n  = tsh;
      tw_n   = tw;
      tidx_n = tidx;
      pop    = 1'b0;
      case (ts)
         T_IDLE: begin
            tcnt_n = '0;
            if (!empty) ts_n = T_LOAD;
         end
         T_LOAD: begin
            pop    = !empty;
            tw_n   = rd_word;
            tsh_n  = rd_word[WW-1 -: 8];
            tidx_n = '0;
            tcnt_n = '0;
            ts_n   = T_START;
         end
         T_START: if (tbit_end) begin
            tcnt_n = '0;
            tbit_n = '0;
            ts_n   = T_DATA;
         end
         T_DATA: if (tbit_end) begin
            tcnt_n = '0;
            tbit_n = tbit + 1'b1;
            tsh_n  = {1'b0, tsh[7:1]};
            if (tbit == 3'd7) ts_n = T_STOP;
         end
         T_STOP: if (tcnt == (more ? CW'(BIT - 2) : CW'(BIT - 3))) begin
            tcnt_n = '0;
            ts_n   = T_NEXT;
         end
         T_NEXT: begin
            tcnt_n = '0;
            ts_n   = more ? T_START : empty ? T_IDLE : T_LOAD;
            if (more) begin
               tw_n   = tw_shl;
               tsh_n  = tw_shl[WW-1 -: 8];
               tidx_n = tidx + 1'b1;
            end
         end
         default: ts_n = T_IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ts             <= T_IDLE;
         tcnt           <= '0;
         tbit           <= '0;
         tsh            <= '0;
         tw             <= '0;
         tidx           <= '0;
         LASER_UART_TXD <= 1'b1;
      end else begin
         ts             <= ts_n;
         tcnt           <= tcnt_n;
         tbit           <= tbit_n;
         tsh            <= tsh_n;
         tw             <= tw_n;
         tidx           <= tidx_n;
         LASER_UART_TXD <= ts_n == T_START ? 1'b0 : ts_n == T_DATA ? tsh_n[0] : 1'b1;
      end
   end
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_st_t;
   rx_st_t        rs, rs_n;
   logic [CW-1:0] rcnt, rcnt_n;
   logic [2:0]    rbit, rbit_n;
   logic [7:0]    rsh, rsh_n, rdata_n;
   logic          rs1, rs2, rprev, vld_n, err_n, rend;
   assign rend = rcnt == CW'(BIT - 1);
   always_comb begin
      rs_n    = rs;
      rcnt_n  = rcnt + 1'b1;
      rbit_n  = rbit;
      rsh_n   = rsh;
      rdata_n = laser_rx_data_o;
      vld_n   = 1'b0;
      err_n   = 1'b0;
      case (rs)
         R_IDLE: begin
            rcnt_n = '0;
            if (rprev && !rs2) rs_n = R_START;
         end
         R_START: if (rcnt == CW'(HALF - 1)) begin
            rcnt_n = '0;
            rbit_n = '0;
            rs_n   = rs2 ? R_IDLE : R_DATA;
         end
         R_DATA: if (rend) begin
            rcnt_n = '0;
            rbit_n = rbit + 1'b1;
            rsh_n  = {rs2, rsh[7:1]};
            if (rbit == 3'd7) rs_n = R_STOP;
         end
         R_STOP: if (rend) begin
            rs_n    = rs2 ? R_IDLE : R_WAIT;
            vld_n   = rs2;
            err_n   = !rs2;
            rdata_n = rs2 ? rsh : laser_rx_data_o;
         end
         R_WAIT: begin
            rcnt_n = '0;
            if (rs2) rs_n = R_IDLE;
         end
         default: rs_n = R_IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         {rs1, rs2, rprev} <= 3'b111;
         rs                <= R_IDLE;
         rcnt              <= '0;
         rbit              <= '0;
         rsh               <= '0;
         laser_rx_data_o   <= '0;
         laser_rx_vld_o    <= 1'b0;
         laser_rx_last_o   <= 1'b0;
         laser_rx_err_o    <= 1'b0;
      end else begin
         {rs1, rs2, rprev} <= {LASER_UART_RXD, rs1, rs2};
         rs                <= rs_n;
         rcnt              <= rcnt_n;
         rbit              <= rbit_n;
         rsh               <= rsh_n;
         laser_rx_data_o   <= rdata_n;
         laser_rx_vld_o    <= vld_n;
         laser_rx_last_o   <= vld_n && rdata_n == EOF_BYTE;
         laser_rx_err_o    <= err_n;
      end
   end
`ifdef LASER_UART_RX_TIMEOUT_EN
   logic        fopen, tout;
   logic [31:0] tocnt;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fopen <= 1'b0;
         tout  <= 1'b0;
         tocnt <= '0;
      end else begin
         tout <= 1'b0;
         if (vld_n) begin
            fopen <= rdata_n != EOF_BYTE;
            tocnt <= '0;
         end else if (fopen && rs == R_IDLE) begin
            tout  <= tocnt == RX_TIMEOUT_CYC - 32'd1;
            fopen <= tocnt != RX_TIMEOUT_CYC - 32'd1;
            tocnt <= tocnt == RX_TIMEOUT_CYC - 32'd1 ? '0 : tocnt + 32'd1;
         end
      end
   end
   assign laser_rx_timeout_o = tout;
`else
   assign laser_rx_timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_laser_uart_frame_ctrl.sv
// tb_laser_uart_frame_ctrl: scoreboard bench for the UART frame controller (PRESCALE=4, FIFO_DEPTH=4).
module tb_laser_uart_frame_ctrl;
   localparam int BIT   = 32;
   localparam int DEPTH = 4;
   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic [31:0] tx_data = '0;
   logic        tx_vld = 1'b0, rxd = 1'b1;
   logic        tx_full, tx_busy, rx_vld, rx_last, rx_err, rx_to, txd;
   logic [7:0]  rx_data;
   int          cyc = 0, n_chk = 0, n_fail = 0;
   bit          tx_ignore = 1'b0;
   typedef struct {logic [7:0] data; int gap;} tx_exp_t;
   typedef struct {int kind; logic [7:0] data; logic last;} rx_exp_t;
   tx_exp_t tx_q[$];
   rx_exp_t rx_q[$];

   laser_uart_frame_ctrl #(
      .PRESCALE(16'd4), .TX_WORD_BYTES(4), .FIFO_DEPTH(DEPTH),
      .EOF_BYTE(8'hFF), .RX_TIMEOUT_CYC(32'd1000)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .laser_tx_data_i(tx_data), .laser_tx_vld_i(tx_vld),
      .laser_tx_full_o(tx_full), .laser_tx_busy_o(tx_busy),
      .laser_rx_data_o(rx_data), .laser_rx_vld_o(rx_vld), .laser_rx_last_o(rx_last),
      .laser_rx_err_o(rx_err), .laser_rx_timeout_o(rx_to),
      .LASER_UART_RXD(rxd), .LASER_UART_TXD(txd)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // TX line decoder: samples mid-bit, compares byte, stop level and start-to-start spacing.
   initial begin : tx_mon
      int last_start = 0, st;
      logic [7:0] b;
      logic sb;
      tx_exp_t e;
      forever begin
         @(negedge clk_i);
         if (!rst_i && txd === 1'b0) begin
            st = cyc;
            repeat (BIT / 2) @(negedge clk_i);
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) @(negedge clk_i);
               b[i] = txd;
            end
            repeat (BIT) @(negedge clk_i);
            sb = txd;
            if (!tx_ignore) begin
               if (tx_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL tx_unexpected_byte: got %0h expected no byte", b);
               end else begin
                  e = tx_q.pop_front();
                  check("tx_byte", {24'd0, b}, {24'd0, e.data});
                  check("tx_stop_bit", {31'd0, sb}, 32'd1);
                  if (e.gap != 0) check("tx_start_spacing", st - last_start, e.gap);
               end
            end
            last_start = st;
         end
      end
   end

   initial begin : rx_mon
      int last_vld = 0;
      rx_exp_t e;
      forever begin
         @(negedge clk_i);
         if (rx_vld || rx_err || rx_to) begin
            if (rx_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL rx_unexpected_event: vld=%0b err=%0b timeout=%0b data=%0h expected none",
                        rx_vld, rx_err, rx_to, rx_data);
            end else begin
               e = rx_q.pop_front();
               check("rx_event", {29'd0, rx_to, rx_err, rx_vld}, e.kind);
               if (e.kind == 1) begin
                  check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                  check("rx_last", {31'd0, rx_last}, {31'd0, e.last});
               end
               if (e.kind == 4) check("rx_timeout_delay", cyc - last_vld, 1000);
            end
            if (rx_vld) last_vld = cyc;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_tx(input logic [7:0] d, input int gap);
      tx_exp_t e;
      e.data = d;
      e.gap  = gap;
      tx_q.push_back(e);
   endtask

   task automatic push_word(input logic [31:0] w, input int first_gap);
      push_tx(w[31:24], first_gap);
      push_tx(w[23:16], 10 * BIT);
      push_tx(w[15:8], 10 * BIT);
      push_tx(w[7:0], 10 * BIT);
   endtask

   task automatic push_rx(input int kind, input logic [7:0] d, input logic last);
      rx_exp_t e;
      e.kind = kind;
      e.data = d;
      e.last = last;
      rx_q.push_back(e);
   endtask

   task automatic wr_word(input logic [31:0] w);
      @(negedge clk_i);
      tx_data = w;
      tx_vld  = 1'b1;
      @(negedge clk_i);
      tx_vld  = 1'b0;
   endtask

   task automatic wait_tx_idle(input int budget);
      int n = 0;
      while ((tx_busy || tx_q.size() != 0) && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= budget) begin
         n_chk++;
         n_fail++;
         $display("FAIL tx_done_wait: busy=%0b pending=%0d expected idle within %0d cycles", tx_busy, tx_q.size(), budget);
      end
      repeat (12 * BIT) @(negedge clk_i);
   endtask

   task automatic rx_bit(input logic v);
      rxd = v;
      repeat (BIT) @(negedge clk_i);
   endtask

   task automatic rx_byte(input logic [7:0] d, input logic stop);
      @(negedge clk_i);
      rx_bit(1'b0);
      for (int i = 0; i < 8; i++) rx_bit(d[i]);
      rx_bit(stop);
      rx_bit(1'b1);
   endtask

   task automatic wait_rx_drain(input int budget);
      int n = 0;
      while (rx_q.size() != 0 && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= budget) begin
         n_chk++;
         n_fail++;
         $display("FAIL rx_drain_wait: pending=%0d expected 0 within %0d cycles", rx_q.size(), budget);
      end
   endtask

   initial begin : stim
      repeat (5) @(negedge clk_i);
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_busy", {31'd0, tx_busy}, 32'd0);
      check("rst_full", {31'd0, tx_full}, 32'd0);
      check("rst_rx_data", {24'd0, rx_data}, 32'd0);
      check("rst_rx_vld", {31'd0, rx_vld}, 32'd0);
      check("rst_rx_last", {31'd0, rx_last}, 32'd0);
      check("rst_rx_err", {31'd0, rx_err}, 32'd0);
      check("rst_rx_timeout", {31'd0, rx_to}, 32'd0);
      rst_i = 1'b0;
      repeat (5) @(negedge clk_i);

      push_word(32'h11223344, 0);
      wr_word(32'h11223344);
      wait_tx_idle(3000);
      check("tx_idle_txd", {31'd0, txd}, 32'd1);

      push_tx(8'hA5, 0);
      push_tx(8'hFF, 10 * BIT);
      wr_word(32'hA5FF0000);
      wait_tx_idle(3000);
      check("tx_busy_after_eof", {31'd0, tx_busy}, 32'd0);

      push_word(32'h10111213, 0);
      wr_word(32'h10111213);
      repeat (8) @(negedge clk_i);
      check("tx_not_full_before_burst", {31'd0, tx_full}, 32'd0);
      for (int i = 0; i < DEPTH + 2; i++) begin
         tx_data = {8'h20 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i), 8'h50 + 8'(i)};
         tx_vld  = 1'b1;
         if (i < DEPTH) push_word(tx_data, 10 * BIT);
         @(negedge clk_i);
      end
      tx_vld = 1'b0;
      check("tx_full_after_burst", {31'd0, tx_full}, 32'd1);
      wait_tx_idle(12000);
      check("tx_full_after_drain", {31'd0, tx_full}, 32'd0);

      push_rx(1, 8'h5A, 1'b0);
      rx_byte(8'h5A, 1'b1);
      push_rx(1, 8'hFF, 1'b1);
      rx_byte(8'hFF, 1'b1);
      wait_rx_drain(500);
      push_rx(2, 8'h00, 1'b0);
      rx_byte(8'h3C, 1'b0);
      wait_rx_drain(500);
      @(negedge clk_i);
      rxd = 1'b0;
      repeat (BIT / 2) @(negedge clk_i);
      rxd = 1'b1;
      repeat (12 * BIT) @(negedge clk_i);
      check("rx_data_after_glitch", {24'd0, rx_data}, 32'hFF);

`ifdef LASER_UART_RX_TIMEOUT_EN
      push_rx(1, 8'h01, 1'b0);
      push_rx(4, 8'h00, 1'b0);
      rx_byte(8'h01, 1'b1);
      repeat (1200) @(negedge clk_i);
      push_rx(1, 8'h01, 1'b0);
      push_rx(1, 8'hFF, 1'b1);
      rx_byte(8'h01, 1'b1);
      rx_byte(8'hFF, 1'b1);
      repeat (1200) @(negedge clk_i);
`else
      push_rx(1, 8'h01, 1'b0);
      rx_byte(8'h01, 1'b1);
      repeat (1200) @(negedge clk_i);
      check("rx_timeout_tied_low", {31'd0, rx_to}, 32'd0);
      push_rx(1, 8'hFF, 1'b1);
      rx_byte(8'hFF, 1'b1);
`endif
      wait_rx_drain(500);

      wr_word(32'h11223344);
      repeat (5 * BIT) @(negedge clk_i);
      tx_ignore = 1'b1;
      rst_i = 1'b1;
      @(negedge clk_i);
      check("rst_mid_byte_txd", {31'd0, txd}, 32'd1);
      check("rst_mid_byte_busy", {31'd0, tx_busy}, 32'd0);
      rst_i = 1'b0;
      repeat (15 * BIT) @(negedge clk_i);
      check("post_abort_txd", {31'd0, txd}, 32'd1);
      check("post_abort_busy", {31'd0, tx_busy}, 32'd0);
      tx_ignore = 1'b0;

      check("tx_queue_empty", tx_q.size(), 32'd0);
      check("rx_queue_empty", rx_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
